// File: rtl/ibex_rvfi_trace_fifo.sv
// ibex_rvfi_trace_fifo
// Captures retired-instruction records from the RVFI port, filters them and
// buffers them in a FIFO that is drained over a valid/ready stream.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   rvfi_*_i               retirement record from the core
//   mode_i                 0 off, 1 all, 2 trap|intr only, 3 PC window
//   pc_lo_i / pc_hi_i      inclusive PC window bounds for mode 3
//   clear_i                flush FIFO and clear overflow/drop accounting
//   out_valid_o/ready_i    head-of-FIFO stream handshake
//   out_data_o             {pc, insn, rd_wdata, rd_addr, trap, intr, mode}
//   level_o                entries held
//   overflow_o             sticky drop flag
//   drop_cnt_o             saturating count of dropped records
module ibex_rvfi_trace_fifo #(
    parameter int unsigned Depth         = 16,
    parameter bit          CaptureRdData = 1'b1,
    parameter int unsigned DropCntW      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       rvfi_valid_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic                       rvfi_trap_i,
    input  logic                       rvfi_intr_i,
    input  logic [1:0]                 rvfi_mode_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
    input  logic [1:0]                 mode_i,
    input  logic [31:0]                pc_lo_i,
    input  logic [31:0]                pc_hi_i,
    input  logic                       clear_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [104:0]               out_data_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       overflow_o,
    output logic [DropCntW-1:0]        drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned RecW = 105;

    logic [RecW-1:0]     mem [Depth];
    logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic [DropCntW-1:0] drop_q, drop_d;
    logic [RecW-1:0]     head_q, head_d;

    logic            match, accept, full, pop, push, drop;
    logic [RecW-1:0] rec;

    // Record filter: decides in the retirement cycle whether to keep it.
    always_comb begin
        match = 1'b0;
        case (mode_i)
            2'd0:    match = 1'b0;
            2'd1:    match = 1'b1;
            2'd2:    match = rvfi_trap_i | rvfi_intr_i;
            default: match = (rvfi_pc_rdata_i >= pc_lo_i) && (rvfi_pc_rdata_i <= pc_hi_i);
        endcase
        accept = rvfi_valid_i & match;
    end

    assign rec = {rvfi_pc_rdata_i, rvfi_insn_i,
                  (CaptureRdData ? rvfi_rd_wdata_i : 32'd0),
                  rvfi_rd_addr_i, rvfi_trap_i, rvfi_intr_i, rvfi_mode_i};

    // Next-state computation for pointers, level, accounting and head register.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        valid_d = 1'b0;
        head_d  = '0;

        full = (level_q == LvlW'(Depth));
        pop  = valid_q & out_ready_i;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push = accept & (~full | pop) & ~clear_i;
        drop = accept & full & ~pop & ~clear_i;

        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PtrW'(1);
            if (pop)  rptr_d = rptr_q + PtrW'(1);
            level_d = level_q + LvlW'(push) - LvlW'(pop);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DropCntW'(1);
            end
        end

        valid_d = (level_d != '0);
        // The new head is the record being written when it lands in the slot
        // the read pointer moves to (i.e. the FIFO was empty after any pop).
        if (valid_d) begin
            if (push && (wptr_q == rptr_d)) head_d = rec;
            else                            head_d = mem[rptr_d];
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem[wptr_q] <= rec;
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            head_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = head_q;
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
// Testbench for ibex_rvfi_trace_fifo: scoreboard of expected records plus
// per-scenario tasks with their own inline checks.
module tb_ibex_rvfi_trace_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DCW   = 2;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int          DMAX  = (1 << DCW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rvfi_valid;
    logic [31:0]   rvfi_pc;
    logic [31:0]   rvfi_insn;
    logic          rvfi_trap;
    logic          rvfi_intr;
    logic [1:0]    rvfi_md;
    logic [4:0]    rvfi_rd;
    logic [31:0]   rvfi_wdata;
    logic [1:0]    mode;
    logic [31:0]   pc_lo;
    logic [31:0]   pc_hi;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [104:0]  out_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic [DCW-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [104:0] exp_q[$];
    int           m_level = 0;
    int           m_drop  = 0;
    logic         m_ovf   = 1'b0;

    always #5 clk = ~clk;

    ibex_rvfi_trace_fifo #(
        .Depth(DEPTH), .CaptureRdData(1'b1), .DropCntW(DCW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rvfi_valid_i(rvfi_valid), .rvfi_pc_rdata_i(rvfi_pc), .rvfi_insn_i(rvfi_insn),
        .rvfi_trap_i(rvfi_trap), .rvfi_intr_i(rvfi_intr), .rvfi_mode_i(rvfi_md),
        .rvfi_rd_addr_i(rvfi_rd), .rvfi_rd_wdata_i(rvfi_wdata),
        .mode_i(mode), .pc_lo_i(pc_lo), .pc_hi_i(pc_hi), .clear_i(clear),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .level_o(level), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
    );

    // Reference model and scoreboard, sampled mid-cycle before the next edge.
    logic         sb_match;
    logic [104:0] sb_rec;
    logic [104:0] sb_exp;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_level = 0;
            m_drop  = 0;
            m_ovf   = 1'b0;
        end else begin
            checks++;
            if (level !== LW'(m_level) || out_valid !== (m_level != 0)) begin
                errors++;
                $display("FAIL sb_level: level=%0d valid=%0b, expected level=%0d", level, out_valid, m_level);
            end
            checks++;
            if (drop_cnt !== DCW'(m_drop) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL sb_drop: drop=%0d ovf=%0b, expected drop=%0d ovf=%0b", drop_cnt, overflow, m_drop, m_ovf);
            end
            if (clear) begin
                exp_q.delete();
                m_level = 0;
                m_drop  = 0;
                m_ovf   = 1'b0;
            end else begin
                case (mode)
                    2'd0: sb_match = 1'b0;
                    2'd1: sb_match = 1'b1;
                    2'd2: sb_match = rvfi_trap | rvfi_intr;
                    default: sb_match = (pc_lo <= rvfi_pc) && (rvfi_pc <= pc_hi);
                endcase
                sb_rec = {rvfi_pc, rvfi_insn, rvfi_wdata, rvfi_rd, rvfi_trap, rvfi_intr, rvfi_md};
                if (m_level != 0 && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_data: pop with empty scoreboard");
                    end else begin
                        sb_exp = exp_q.pop_front();
                        if (out_data !== sb_exp) begin
                            errors++;
                            $display("FAIL sb_data: got %h, expected %h", out_data, sb_exp);
                        end
                    end
                    m_level--;
                end
                if (rvfi_valid && sb_match) begin
                    if (m_level < DEPTH) begin
                        exp_q.push_back(sb_rec);
                        m_level++;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < DMAX) m_drop++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic trap, input logic intr);
        rvfi_valid = 1'b1;
        rvfi_pc    = pc;
        rvfi_insn  = $urandom;
        rvfi_wdata = $urandom;
        rvfi_rd    = 5'($urandom);
        rvfi_md    = 2'($urandom);
        rvfi_trap  = trap;
        rvfi_intr  = intr;
        step();
        rvfi_valid = 1'b0;
        rvfi_trap  = 1'b0;
        rvfi_intr  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (level !== '0 && n < 20) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (level !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: level=%0d left=%0d, expected 0", level, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rvfi_valid = 1'b1;
        mode = 2'd1;
        out_ready = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 ||
            drop_cnt !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset: valid=%0b level=%0d ovf=%0b drop=%0d data=%h, expected all 0",
                     out_valid, level, overflow, drop_cnt, out_data);
        end
        rvfi_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_in_order();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        mode = 2'd1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            retire(pcs[i], 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data[104:73] !== pcs[i]) begin
                errors++;
                $display("FAIL in_order[%0d]: valid=%0b pc=%h, expected 1 %h", i, out_valid, out_data[104:73], pcs[i]);
            end
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL in_order_empty: valid=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        mode = 2'd1;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) retire(32'h1000 + 32'(i * 4), 1'b0, 1'b0);
        checks++;
        if (level !== LW'(DEPTH) || overflow !== 1'b1 || drop_cnt !== DCW'(2)) begin
            errors++;
            $display("FAIL overflow: level=%0d ovf=%0b drop=%0d, expected %0d 1 2", level, overflow, drop_cnt, DEPTH);
        end
        checks++;
        if (out_data[104:73] !== 32'h1000) begin
            errors++;
            $display("FAIL overflow_head: pc=%h, expected 00001000", out_data[104:73]);
        end
        drain();
    endtask

    task automatic test_full_pop();
        mode = 2'd1;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) retire(32'h2000 + 32'(i * 4), 1'b0, 1'b0);
        out_ready = 1'b1;
        retire(32'h2100, 1'b0, 1'b0);
        out_ready = 1'b0;
        checks++;
        if (level !== LW'(DEPTH) || drop_cnt !== DCW'(2)) begin
            errors++;
            $display("FAIL full_pop: level=%0d drop=%0d, expected %0d 2", level, drop_cnt, DEPTH);
        end
        drain();
    endtask

    task automatic test_trap_mode();
        do_clear();
        mode = 2'd2;
        out_ready = 1'b0;
        retire(32'h300, 1'b0, 1'b0);
        retire(32'h304, 1'b1, 1'b0);
        retire(32'h308, 1'b0, 1'b1);
        checks++;
        if (level !== LW'(2) || out_data[3] !== 1'b1 || out_data[2] !== 1'b0) begin
            errors++;
            $display("FAIL trap_mode: level=%0d trap=%0b intr=%0b, expected 2 1 0", level, out_data[3], out_data[2]);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_data[3] !== 1'b0 || out_data[2] !== 1'b1) begin
            errors++;
            $display("FAIL trap_mode_intr: trap=%0b intr=%0b, expected 0 1", out_data[3], out_data[2]);
        end
        drain();
    endtask

    task automatic test_pc_window();
        logic [31:0] pcs [4];
        pcs[0] = 32'h1FC; pcs[1] = 32'h200; pcs[2] = 32'h20C; pcs[3] = 32'h210;
        mode = 2'd3;
        pc_lo = 32'h200;
        pc_hi = 32'h20C;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) retire(pcs[i], 1'b0, 1'b0);
        checks++;
        if (level !== LW'(2) || out_data[104:73] !== 32'h200) begin
            errors++;
            $display("FAIL pc_window: level=%0d head=%h, expected 2 00000200", level, out_data[104:73]);
        end
        drain();
        // Inverted window and mode 0 accept nothing.
        pc_lo = 32'h300;
        pc_hi = 32'h100;
        retire(32'h200, 1'b0, 1'b0);
        mode = 2'd0;
        retire(32'h200, 1'b1, 1'b1);
        checks++;
        if (level !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_match: level=%0d valid=%0b, expected 0 0", level, out_valid);
        end
    endtask

    task automatic test_saturate_clear();
        do_clear();
        mode = 2'd1;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 5; i++) retire(32'h4000 + 32'(i * 4), 1'b0, 1'b0);
        checks++;
        if (drop_cnt !== DCW'(DMAX) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL saturate: drop=%0d ovf=%0b, expected %0d 1", drop_cnt, overflow, DMAX);
        end
        clear = 1'b1;
        out_ready = 1'b1;
        retire(32'h5000, 1'b0, 1'b0);
        clear = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (level !== '0 || drop_cnt !== '0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear: level=%0d drop=%0d ovf=%0b valid=%0b, expected all 0",
                     level, drop_cnt, overflow, out_valid);
        end
    endtask

    task automatic test_back_to_back_reset();
        mode = 2'd1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) retire(32'h6000 + 32'(i * 4), 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (level !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: level=%0d valid=%0b data=%h, expected 0", level, out_valid, out_data);
        end
        step();
        // Normal operation resumes after the reset.
        out_ready = 1'b1;
        retire(32'h7000, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data[104:73] !== 32'h7000) begin
            errors++;
            $display("FAIL post_reset: valid=%0b pc=%h, expected 1 00007000", out_valid, out_data[104:73]);
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rvfi_valid = 1'b0;
        rvfi_pc = '0;
        rvfi_insn = '0;
        rvfi_trap = 1'b0;
        rvfi_intr = 1'b0;
        rvfi_md = '0;
        rvfi_rd = '0;
        rvfi_wdata = '0;
        mode = 2'd0;
        pc_lo = '0;
        pc_hi = '0;
        clear = 1'b0;
        out_ready = 1'b0;

        test_reset();
        test_in_order();
        test_overflow();
        test_full_pop();
        test_trap_mode();
        test_pc_window();
        test_saturate_clear();
        test_back_to_back_reset();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
